// File: rtl/ls_pkg.sv
// Shared constants and helpers for the ls-series counter models.
// Holds the divide-by-5 encoding, BCD nine and synchronizer depth limit.
package ls_pkg;

  localparam logic [2:0] DIV5_LAST       = 3'd4;
  localparam logic [3:0] BCD_NINE        = 4'b1001;
  localparam int         MAX_SYNC_STAGES = 3;

  typedef enum logic [2:0] {
    D5_S0 = 3'd0,
    D5_S1 = 3'd1,
    D5_S2 = 3'd2,
    D5_S3 = 3'd3,
    D5_S4 = 3'd4
  } div5_e;

  // Next divide-by-5 count; 101/110/111 fold back to 000.
  function automatic div5_e div5_next(input div5_e cur);
    div5_e nxt;
    case (cur)
      D5_S0:   nxt = D5_S1;
      D5_S1:   nxt = D5_S2;
      D5_S2:   nxt = D5_S3;
      D5_S3:   nxt = D5_S4;
      default: nxt = D5_S0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ls_edge_sync.sv
// Pin synchronizer (0..3 flops) followed by a falling-edge detector.
// Ports: clk, rst (sync, high), pin in; s = synced level, fall = 1-cycle tick.
module ls_edge_sync
  import ls_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic s,
  output logic fall
);

  logic prev;

  if (SYNC_STAGES < 0 || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad
    $error("ls_edge_sync: SYNC_STAGES out of range");
  end

  if (SYNC_STAGES == 0) begin : g_direct
    assign s = pin;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync;

    always_ff @(posedge clk) begin
      if (rst) begin
        sync <= '0;
      end else begin
        sync[0] <= pin;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          sync[i] <= sync[i-1];
        end
      end
    end

    assign s = sync[SYNC_STAGES-1];
  end

  // prev resets low so a pin held low across reset gives no tick.
  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= s;
  end

  assign fall = prev & ~s;

endmodule

// File: rtl/ls90_sync.sv
// SN74LS90 decade counter, clock pins sampled by clk (divide-by-2 + divide-by-5).
// Ports: clk, rst, _CKA/_CKB clock pins, _R01/_R02/_R91/_R92 gates, _QA.._QD.
module ls90_sync
  import ls_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic _CKA,
  input  logic _CKB,
  input  logic _R01,
  input  logic _R02,
  input  logic _R91,
  input  logic _R92,
  output logic _QA,
  output logic _QB,
  output logic _QC,
  output logic _QD
);

  logic       tick_a;
  logic       tick_b;
  logic       s_cka_unused;
  logic       s_ckb_unused;
  logic [3:0] gate_fall_unused;
  logic       s_r01;
  logic       s_r02;
  logic       s_r91;
  logic       s_r92;
  logic       r0;
  logic       r9;

  logic       qa_q;
  logic       qa_d;
  div5_e      d5_q;
  div5_e      d5_d;

  ls_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cka (
    .clk (clk),
    .rst (rst),
    .pin (_CKA),
    .s   (s_cka_unused),
    .fall(tick_a)
  );

  ls_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ckb (
    .clk (clk),
    .rst (rst),
    .pin (_CKB),
    .s   (s_ckb_unused),
    .fall(tick_b)
  );

  ls_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_r01 (
    .clk (clk),
    .rst (rst),
    .pin (_R01),
    .s   (s_r01),
    .fall(gate_fall_unused[0])
  );

  ls_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_r02 (
    .clk (clk),
    .rst (rst),
    .pin (_R02),
    .s   (s_r02),
    .fall(gate_fall_unused[1])
  );

  ls_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_r91 (
    .clk (clk),
    .rst (rst),
    .pin (_R91),
    .s   (s_r91),
    .fall(gate_fall_unused[2])
  );

  ls_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_r92 (
    .clk (clk),
    .rst (rst),
    .pin (_R92),
    .s   (s_r92),
    .fall(gate_fall_unused[3])
  );

  assign r0 = s_r01 & s_r02;
  assign r9 = s_r91 & s_r92;

  always_ff @(posedge clk) begin
    if (rst) begin
      qa_q <= 1'b0;
      d5_q <= D5_S0;
    end else begin
      qa_q <= qa_d;
      d5_q <= d5_d;
    end
  end

  // Set-to-9 beats reset-to-0; ticks under either gate are dropped.
  always_comb begin
    qa_d = qa_q;
    d5_d = d5_q;
    if (r9) begin
      qa_d = BCD_NINE[0];
      d5_d = div5_e'(BCD_NINE[3:1]);
    end else if (r0) begin
      qa_d = 1'b0;
      d5_d = D5_S0;
    end else begin
      if (tick_a) qa_d = ~qa_q;
      if (tick_b) d5_d = div5_next(d5_q);
    end
  end

  always_comb begin
    _QA = qa_q;
    {_QD, _QC, _QB} = d5_q;
  end

endmodule

// File: tb/tb_ls90_sync.sv
// Self-checking bench for ls90_sync (SYNC_STAGES=2 and 0 instances).
// Expected counts are queued on stimulus and popped when outputs settle.
module tb_ls90_sync;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bcd = 1'b0;
  logic cka = 1'b0, ckb = 1'b0;
  logic r01 = 1'b0, r02 = 1'b0, r91 = 1'b0, r92 = 1'b0;
  logic ckb_pin;
  logic qa2, qb2, qc2, qd2;
  logic a0 = 1'b0, b0 = 1'b0;
  logic qa0, qb0, qc0, qd0;

  int tests = 0;
  int fails = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp;

  always #5 clk = ~clk;

  assign ckb_pin = bcd ? qa2 : ckb;

  ls90_sync #(.SYNC_STAGES(2)) dut2 (
    .clk(clk), .rst(rst),
    ._CKA(cka), ._CKB(ckb_pin),
    ._R01(r01), ._R02(r02), ._R91(r91), ._R92(r92),
    ._QA(qa2), ._QB(qb2), ._QC(qc2), ._QD(qd2)
  );

  ls90_sync #(.SYNC_STAGES(0)) dut0 (
    .clk(clk), .rst(rst),
    ._CKA(a0), ._CKB(b0),
    ._R01(1'b0), ._R02(1'b0), ._R91(1'b0), ._R92(1'b0),
    ._QA(qa0), ._QB(qb0), ._QC(qc0), ._QD(qd0)
  );

  function automatic logic [3:0] q2();
    return {qd2, qc2, qb2, qa2};
  endfunction

  function automatic logic [9:0] ls42(input logic [3:0] v);
    logic [9:0] o;
    o = '1;
    if (v < 4'd10) o[v] = 1'b0;
    return o;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
  endtask

  task automatic pulse_a(input int hi, input int lo);
    cka = 1'b1; cycles(hi);
    cka = 1'b0; cycles(lo);
  endtask

  task automatic pulse_b();
    ckb = 1'b1; cycles(8);
    ckb = 1'b0; cycles(8);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; cka = 1'b0; ckb = 1'b0; bcd = 1'b0;
    cycles(3);
    exp_q.push_back(4'b0000);
    exp = exp_q.pop_front();
    tests++;
    if (q2() !== exp || {qd0, qc0, qb0, qa0} !== exp) begin
      $display("FAIL reset: got %b/%b want %b", q2(), {qd0, qc0, qb0, qa0}, exp);
      fails++;
    end
    rst = 1'b0;
  endtask

  task automatic test_bcd_decade();
    do_reset();
    bcd = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      pulse_a(8, 8);
      exp_q.push_back(4'(i % 10));
      exp = exp_q.pop_front();
      tests++;
      if (q2() !== exp) begin
        $display("FAIL bcd_count[%0d]: got %b want %b", i, q2(), exp);
        fails++;
      end
      tests++;
      if (ls42(q2()) !== ls42(exp)) begin
        $display("FAIL ls42[%0d]: got %b want %b", i, ls42(q2()), ls42(exp));
        fails++;
      end
    end
    bcd = 1'b0;
  endtask

  task automatic test_div5();
    logic [2:0] c;
    do_reset();
    c = 3'd0;
    for (int i = 0; i < 6; i++) begin
      pulse_b();
      c = (c == 3'd4) ? 3'd0 : c + 3'd1;
      exp_q.push_back({c, 1'b0});
      exp = exp_q.pop_front();
      tests++;
      if (q2() !== exp) begin
        $display("FAIL div5[%0d]: got %b want %b", i, q2(), exp);
        fails++;
      end
    end
  endtask

  task automatic test_set9();
    do_reset();
    pulse_a(8, 8);
    pulse_b();
    exp_q.push_back(4'b0011);
    exp = exp_q.pop_front();
    tests++;
    if (q2() !== exp) begin
      $display("FAIL set9_pre: got %b want %b", q2(), exp);
      fails++;
    end
    r91 = 1'b1; r92 = 1'b1;
    cycles(2);
    exp_q.push_back(4'b0011);
    exp = exp_q.pop_front();
    tests++;
    if (q2() !== exp) begin
      $display("FAIL set9_early: got %b want %b", q2(), exp);
      fails++;
    end
    cycles(1);
    exp_q.push_back(4'b1001);
    exp = exp_q.pop_front();
    tests++;
    if (q2() !== exp) begin
      $display("FAIL set9_lat: got %b want %b", q2(), exp);
      fails++;
    end
    r01 = 1'b1; r02 = 1'b1;
    cycles(5);
    exp_q.push_back(4'b1001);
    exp = exp_q.pop_front();
    tests++;
    if (q2() !== exp) begin
      $display("FAIL set9_over_r0: got %b want %b", q2(), exp);
      fails++;
    end
    r91 = 1'b0; r92 = 1'b0;
    cycles(5);
    exp_q.push_back(4'b0000);
    exp = exp_q.pop_front();
    tests++;
    if (q2() !== exp) begin
      $display("FAIL r0_after_r9: got %b want %b", q2(), exp);
      fails++;
    end
    r01 = 1'b0; r02 = 1'b0;
    cycles(4);
  endtask

  task automatic test_gate_r0();
    logic qa_m;
    do_reset();
    r01 = 1'b1; r02 = 1'b0;
    qa_m = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pulse_a(8, 8);
      qa_m = ~qa_m;
      exp_q.push_back({3'b000, qa_m});
      exp = exp_q.pop_front();
      tests++;
      if (q2() !== exp) begin
        $display("FAIL one_gate[%0d]: got %b want %b", i, q2(), exp);
        fails++;
      end
    end
    r02 = 1'b1;
    cycles(4);
    pulse_a(8, 8);
    pulse_a(8, 8);
    exp_q.push_back(4'b0000);
    exp = exp_q.pop_front();
    tests++;
    if (q2() !== exp) begin
      $display("FAIL r0_hold: got %b want %b", q2(), exp);
      fails++;
    end
    r01 = 1'b0; r02 = 1'b0;
    cycles(4);
    pulse_a(8, 8);
    exp_q.push_back(4'b0001);
    exp = exp_q.pop_front();
    tests++;
    if (q2() !== exp) begin
      $display("FAIL r0_release: got %b want %b", q2(), exp);
      fails++;
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    pulse_b(); pulse_b(); pulse_b();
    pulse_a(8, 8);
    exp_q.push_back(4'b0111);
    exp = exp_q.pop_front();
    tests++;
    if (q2() !== exp) begin
      $display("FAIL pre_rst: got %b want %b", q2(), exp);
      fails++;
    end
    rst = 1'b1;
    cycles(1);
    exp_q.push_back(4'b0000);
    exp = exp_q.pop_front();
    tests++;
    if (q2() !== exp) begin
      $display("FAIL mid_rst: got %b want %b", q2(), exp);
      fails++;
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycles(1);
      exp_q.push_back(4'b0000);
      exp = exp_q.pop_front();
      tests++;
      if (q2() !== exp) begin
        $display("FAIL no_spurious[%0d]: got %b want %b", i, q2(), exp);
        fails++;
      end
    end
    pulse_a(5, 5);
    exp_q.push_back(4'b0001);
    exp = exp_q.pop_front();
    tests++;
    if (q2() !== exp) begin
      $display("FAIL post_rst_cnt: got %b want %b", q2(), exp);
      fails++;
    end
  endtask

  task automatic test_latency();
    int n;
    logic old;
    do_reset();
    a0 = 1'b1; cycles(3);
    old = qa0;
    a0 = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n++;
      if (qa0 !== old) break;
    end
    tests++;
    if (n !== 1 || qa0 === old) begin
      $display("FAIL lat_s0: got %0d edges want 1", n);
      fails++;
    end
    @(negedge clk);
    cka = 1'b1; cycles(4);
    old = qa2;
    cka = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n++;
      if (qa2 !== old) break;
    end
    tests++;
    if (n !== 3 || qa2 === old) begin
      $display("FAIL lat_s2: got %0d edges want 3", n);
      fails++;
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    a0 = 1'b1; b0 = 1'b1;
    cka = 1'b1; ckb = 1'b1;
    cycles(4);
    a0 = 1'b0; b0 = 1'b0;
    cka = 1'b0; ckb = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(4'b0011);
    exp = exp_q.pop_front();
    tests++;
    if ({qd0, qc0, qb0, qa0} !== exp) begin
      $display("FAIL simul_s0: got %b want %b", {qd0, qc0, qb0, qa0}, exp);
      fails++;
    end
    cycles(4);
    exp_q.push_back(4'b0011);
    exp = exp_q.pop_front();
    tests++;
    if (q2() !== exp) begin
      $display("FAIL simul_s2: got %b want %b", q2(), exp);
      fails++;
    end
  endtask

  initial begin
    test_reset();
    test_bcd_decade();
    test_div5();
    test_set9();
    test_gate_r0();
    test_mid_reset();
    test_latency();
    test_simultaneous();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ls90_sync.md
Name: ls90_sync

Overview:
- Synchronous-domain model of the SN74LS90 decade counter: a divide-by-2 section (QA) and a divide-by-5 section (QB..QD).
- It is the upstream stage of the ls42 decoder. In BCD wiring, QA drives _CKB externally, and QD,QC,QB,QA feed ls42 _D,_C,_B,_A to form a 1-of-10 sequencer.
- Chip clock pins are sampled by the system clock, and counting happens on detected falling edges. There are no asynchronous paths.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on each of _CKA/_CKB/_R01/_R02/_R91/_R92. Legal range 0..3; 0 means pins are sampled directly by the edge detector.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
_CKA  input  1  divide-by-2 clock pin; the QA section advances on its falling edge
_CKB  input  1  divide-by-5 clock pin; the QB..QD section advances on its falling edge
_R01  input  1  reset-to-0 gate input 1
_R02  input  1  reset-to-0 gate input 2
_R91  input  1  set-to-9 gate input 1
_R92  input  1  set-to-9 gate input 2
_QA  output  1  divide-by-2 output (BCD weight 1)
_QB  output  1  divide-by-5 bit 0 (BCD weight 2)
_QC  output  1  divide-by-5 bit 1 (BCD weight 4)
_QD  output  1  divide-by-5 bit 2 (BCD weight 8)

Behaviour:
- Clocking and reset: one clock domain, clk. rst is synchronous and active-high.
- Reset values: while rst=1, at each clk edge QA..QD=0000, all synchronizer flops=0 and the edge-detect "prev" flops=0.
  - Because prev resets to 0, a pin held low through reset deassertion produces no spurious tick.
- Edge detect: s = pin after SYNC_STAGES flops; tick = prev & ~s; prev <= s every cycle.
- Latency: a pin falling before clk edge k changes Q after edge k+SYNC_STAGES.
  - That is SYNC_STAGES+1 sampling edges: 1 edge for SYNC_STAGES=0, 3 edges for the default.
- QA section: on tickA, QA <= ~QA.
- Divide-by-5 section: count = {QD,QC,QB}.
  - On tickB: 000->001->010->011->100->000.
  - Unreachable values 101/110/111 go to 000 on the next tickB.
- Gate terms use the synchronized values: R0 = sR01 & sR02, R9 = sR91 & sR92.
- Priority per clk edge, highest first:
  1. rst -> 0000.
  2. R9 -> QD,QC,QB,QA = 1001.
  3. R0 -> 0000.
  4. Ticks.
- R9 overrides R0, matching the datasheet function table.
- While R0 or R9 is active, ticks are discarded, not deferred; prev still updates.
- Only one gate input high has no effect.
- Simultaneous tickA and tickB in one cycle: both sections advance independently in that same edge.
- BCD wiring (QA -> _CKB): QA falling 1->0 produces tickB after the same latency. The decade sequence is 0..9,0 with transient intermediate states lasting SYNC_STAGES+1 cycles.
  - Downstream consumers sample only after settling.
- rst asserted mid-count: outputs 0000 at the first edge with rst=1, regardless of pins.

Decomposition:
- Shared package ls_pkg holds:
  - DIV5_LAST = 3'd4.
  - BCD_NINE = 4'b1001.
  - MAX_SYNC_STAGES = 3.
  - These are reused by the other ls-series counters.
- One sub-module: ls_edge_sync, a parameterized synchronizer plus falling-edge detector.
  - Output s (synchronized level) and fall (tick).
  - Instantiated six times; the four gate pins use only s.

Test Plan:
1. rst, then BCD wiring with 10 _CKA pulses (high 8 clk, low 8 clk). QDQCQBQA settles to 0001,0010,...,1001,0000; the chained ls42 drives exactly one of _0.._9 low per count.
2. _CKB only, 6 pulses with _CKA static. QDQCQB = 001,010,011,100,000,001; QA stays 0.
3. Count at 0011, drive _R91=_R92=1. Output is 1001 after SYNC_STAGES+1 edges. Adding _R01=_R02=1 keeps 1001; dropping R9 gives 0000.
4. _R01=1,_R02=0 with 3 _CKA pulses -> 1,0,1 (no reset). _R01=_R02=1 with 2 _CKA pulses -> 0000 and no count. Release, then 1 pulse -> QA=1.
5. Count 0111 with _CKA low; assert rst -> 0000 next edge. Deassert with _CKA still low -> no change for 10 cycles. Then _CKA high then low -> QA=1.
6. Latency check for SYNC_STAGES=0 and 2: edges from _CKA fall to QA change = 1 and 3. Simultaneous _CKA/_CKB falls from 0000 -> 0011 in one edge.
